// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU: fetches the opcode
// (plus an optional immediate) over req/ack, drives decoder fields and resolves jumps.
module cpu_sequencer #(
  parameter int PC_W = 8,
  parameter int IW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [IW-1:0]   mem_rdata,
  input  logic            alu_carry,
  output logic [1:0]      select,
  output logic            p_m,
  output logic            we,
  output logic            im_st,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic [IW-1:0]   imm,
  output logic            carry,
  output logic            exec_en,
  output logic            halted,
  output logic            busy
);

  localparam logic [IW-1:0] HALT_OP = IW'(8'hC0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_IMM,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [IW-1:0]   ir_reg, ir_next;
  logic [IW-1:0]   imm_reg, imm_next;
  logic            carry_reg, carry_next;
  logic            mem_req_reg, mem_req_next;
  logic            fetch_done;
  logic            is_jump;
  logic            take_jump;

  // An ack only counts while our own request is up; stray acks are dropped.
  assign fetch_done = mem_req_reg & mem_ack;
  assign is_jump    = (ir_reg[7:6] == 2'b11) & ~ir_reg[4] & ir_reg[3];
  assign take_jump  = is_jump & (~ir_reg[5] | carry_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      imm_reg     <= '0;
      carry_reg   <= 1'b0;
      mem_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      imm_reg     <= imm_next;
      carry_reg   <= carry_next;
      mem_req_reg <= mem_req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    imm_next   = imm_reg;
    carry_next = carry_reg;
    case (state_reg)
      S_IDLE: begin
        if (run || step) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) begin
          ir_next    = mem_rdata;
          imm_next   = '0;
          pc_next    = pc_reg + 1'b1;
          state_next = mem_rdata[3] ? S_FETCH_IMM : S_DECODE;
        end
      end
      S_FETCH_IMM: begin
        if (fetch_done) begin
          imm_next   = mem_rdata;
          pc_next    = pc_reg + 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (ir_reg == HALT_OP) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // Jumps never touch carry, taken or not.
        if (take_jump) begin
          pc_next = PC_W'(imm_reg);
        end else if (!is_jump && ir_reg[4]) begin
          carry_next = alu_carry;
        end
        state_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Request is registered: it rises with entry to a fetch state and drops after the ack.
    mem_req_next = (state_next == S_FETCH) || (state_next == S_FETCH_IMM);
  end

  assign mem_addr = pc_reg;
  assign mem_req  = mem_req_reg;
  assign select   = ir_reg[7:6];
  assign p_m      = ir_reg[5];
  assign we       = ir_reg[4];
  assign im_st    = ir_reg[3];
  assign a        = ir_reg[2];
  assign b        = ir_reg[1];
  assign c        = ir_reg[0];
  assign imm      = imm_reg;
  assign carry    = carry_reg;
  assign exec_en  = (state_reg == S_EXEC);
  assign halted   = (state_reg == S_HALT);
  assign busy     = (state_reg != S_IDLE) && (state_reg != S_HALT);

endmodule
